stream_packet_arbiter: RTL

STREAM_PACKET_ARBITER -- requirements
Module: stream_packet_arbiter

---
 rtl/stream_packet_arbiter_if.sv | 36 +++
 rtl/stream_packet_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/stream_packet_arbiter_if.sv
// rtl/stream_packet_arbiter_if.sv - stream handshake bundle for stream_packet_arbiter
interface stream_packet_arbiter_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] s_axis_tdata_0;
  logic              s_axis_tvalid_0;
  logic              s_axis_tlast_0;
  logic              s_axis_tready_0;
  logic [DATA_W-1:0] s_axis_tdata_1;
  logic              s_axis_tvalid_1;
  logic              s_axis_tlast_1;
  logic              s_axis_tready_1;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              m_axis_tid;

  // Arbiter side: sinks both input channels, sources the merged stream.
  modport slave (
    input  s_axis_tdata_0, s_axis_tvalid_0, s_axis_tlast_0,
    input  s_axis_tdata_1, s_axis_tvalid_1, s_axis_tlast_1,
    output s_axis_tready_0, s_axis_tready_1,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid,
    input  m_axis_tready
  );

  // Environment side: sources both input channels, sinks the merged stream.
  modport master (
    output s_axis_tdata_0, s_axis_tvalid_0, s_axis_tlast_0,
    output s_axis_tdata_1, s_axis_tvalid_1, s_axis_tlast_1,
    input  s_axis_tready_0, s_axis_tready_1,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid,
    output m_axis_tready
  );
endinterface

// File: rtl/stream_packet_arbiter.sv
// rtl/stream_packet_arbiter.sv - two-channel round-robin packet arbiter with length truncation
module stream_packet_arbiter #(
  parameter int DATA_W    = 24,
  parameter int MAX_BEATS = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  stream_packet_arbiter_if.slave  bus,
  input  logic [1:0]              ch_en,
  input  logic                    err_clr,
  output logic                    status_overlength,
  output logic [15:0]             pkt_cnt_0,
  output logic [15:0]             pkt_cnt_1,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              grant_q;
  logic              last_grant_q;
  logic [7:0]        beat_cnt_q;
  logic [DATA_W-1:0] m_data_q;
  logic              m_valid_q;
  logic              m_last_q;
  logic              m_tid_q;

  logic              req_0;
  logic              req_1;
  logic              g_valid;
  logic              g_last;
  logic [DATA_W-1:0] g_data;
  logic              out_free;
  logic              at_max;
  logic              g_ready;
  logic              grant_now;
  logic              grant_ch;
  logic              pkt_done;
  logic              ovf_set;
  logic              take_beat;

  assign req_0    = bus.s_axis_tvalid_0 & ch_en[0];
  assign req_1    = bus.s_axis_tvalid_1 & ch_en[1];
  assign g_valid  = grant_q ? bus.s_axis_tvalid_1 : bus.s_axis_tvalid_0;
  assign g_last   = grant_q ? bus.s_axis_tlast_1  : bus.s_axis_tlast_0;
  assign g_data   = grant_q ? bus.s_axis_tdata_1  : bus.s_axis_tdata_0;
  // The output stage can take a new beat when empty or being emptied this cycle.
  assign out_free = ~m_valid_q | bus.m_axis_tready;
  // The beat being offered now would be the MAX_BEATS-th of the packet.
  assign at_max   = (beat_cnt_q == 8'(MAX_BEATS - 1));
  assign take_beat = (state_q == XFER) & g_valid & out_free;

  // Next-state, grant selection and per-beat decisions.
  always_comb begin
    state_d   = state_q;
    g_ready   = 1'b0;
    grant_now = 1'b0;
    grant_ch  = last_grant_q;
    pkt_done  = 1'b0;
    ovf_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_0 | req_1) begin
          grant_now = 1'b1;
          grant_ch  = (req_0 & req_1) ? ~last_grant_q : req_1;
          state_d   = XFER;
        end
      end
      XFER: begin
        g_ready = out_free;
        if (g_valid & out_free) begin
          if (g_last) begin
            pkt_done = 1'b1;
            state_d  = IDLE;
          end else if (at_max) begin
            pkt_done = 1'b1;
            ovf_set  = 1'b1;
            state_d  = DRAIN;
          end
        end
      end
      DRAIN: begin
        g_ready = 1'b1;
        if (g_valid & g_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.s_axis_tready_0 = g_ready & ~grant_q;
  assign bus.s_axis_tready_1 = g_ready &  grant_q;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant bookkeeping; last_grant resets to 1 so channel 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= 8'd0;
    end else if (grant_now) begin
      grant_q      <= grant_ch;
      last_grant_q <= grant_ch;
      beat_cnt_q   <= 8'd0;
    end else if (take_beat) begin
      beat_cnt_q   <= beat_cnt_q + 8'd1;
    end
  end

  // Single output register stage; a truncated packet gets tlast on its final kept beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_tid_q   <= 1'b0;
    end else if (take_beat) begin
      m_data_q  <= g_data;
      m_valid_q <= 1'b1;
      m_last_q  <= g_last | at_max;
      m_tid_q   <= grant_q;
    end else if (m_valid_q & bus.m_axis_tready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign bus.m_axis_tdata  = m_data_q;
  assign bus.m_axis_tvalid = m_valid_q;
  assign bus.m_axis_tlast  = m_last_q;
  assign bus.m_axis_tid    = m_tid_q;

  // Per-channel completed-packet counters, free-running wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_0 <= 16'd0;
      pkt_cnt_1 <= 16'd0;
    end else if (pkt_done) begin
      if (grant_q) begin
        pkt_cnt_1 <= pkt_cnt_1 + 16'd1;
      end else begin
        pkt_cnt_0 <= pkt_cnt_0 + 16'd1;
      end
    end
  end

  // Sticky truncation flag; a new truncation beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_overlength <= 1'b0;
    end else if (ovf_set) begin
      status_overlength <= 1'b1;
    end else if (err_clr) begin
      status_overlength <= 1'b0;
    end
  end

  // Busy tracks the registered state, so it follows the FSM with no extra lag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
    end
  end

endmodule
